// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: assembles PS/2 set-2 scan-code sequences into key events with modifier tracking and ASCII
module ps2_key_decoder #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data_in,
  input  logic       ps2_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic [7:0] ascii,
  output logic       shift,
  output logic       caps,
  output logic       err
);
  localparam int TW = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer;
  logic          shift_l, shift_r, caps_held;
  logic          ev, ev_ext, ev_brk, err_n;
  logic          is_e0, is_f0, is_pfx, drop, expired;

  assign is_e0   = ps2_data_in == 8'hE0;
  assign is_f0   = ps2_data_in == 8'hF0;
  assign is_pfx  = is_e0 | is_f0;
  assign drop    = ps2_data_in == 8'h00 || ps2_data_in == 8'hAA || ps2_data_in == 8'hEE ||
                   ps2_data_in == 8'hFA || ps2_data_in == 8'hFE || ps2_data_in == 8'hFF;
  assign expired = timer == TW'(TIMEOUT_CYC - 1);
  assign shift   = shift_l | shift_r;

  // Set-2 US-layout translation; letters fold to uppercase when up is set
  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic up);
    logic [7:0] b;
    b = 8'h00;
    case (c)
      8'h1C: b = "a"; 8'h32: b = "b"; 8'h21: b = "c"; 8'h23: b = "d"; 8'h24: b = "e";
      8'h2B: b = "f"; 8'h34: b = "g"; 8'h33: b = "h"; 8'h43: b = "i"; 8'h3B: b = "j";
      8'h42: b = "k"; 8'h4B: b = "l"; 8'h3A: b = "m"; 8'h31: b = "n"; 8'h44: b = "o";
      8'h4D: b = "p"; 8'h15: b = "q"; 8'h2D: b = "r"; 8'h1B: b = "s"; 8'h2C: b = "t";
      8'h3C: b = "u"; 8'h2A: b = "v"; 8'h1D: b = "w"; 8'h22: b = "x"; 8'h35: b = "y";
      8'h1A: b = "z";
      8'h45: b = "0"; 8'h16: b = "1"; 8'h1E: b = "2"; 8'h26: b = "3"; 8'h25: b = "4";
      8'h2E: b = "5"; 8'h36: b = "6"; 8'h3D: b = "7"; 8'h3E: b = "8"; 8'h46: b = "9";
      8'h29: b = 8'h20; 8'h5A: b = 8'h0D; 8'h66: b = 8'h08; 8'h0D: b = 8'h09; 8'h76: b = 8'h1B;
      default: b = 8'h00;
    endcase
    return (up && b >= "a" && b <= "z") ? b - 8'h20 : b;
  endfunction

  // Sequence state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;

  // Next state and event/error decode; a byte always takes priority over a coinciding timeout
  always_comb begin
    state_n = state;
    ev      = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    err_n   = 1'b0;
    if (ps2_valid)
      case (state)
        IDLE: begin
          state_n = is_e0 ? GOT_E0 : is_f0 ? GOT_F0 : IDLE;
          ev      = !is_pfx && !drop;
        end
        GOT_E0: begin
          state_n = is_f0 ? GOT_E0F0 : is_e0 ? GOT_E0 : IDLE;
          ev      = !is_pfx;
          ev_ext  = 1'b1;
        end
        GOT_F0: begin
          state_n = IDLE;
          ev      = !is_pfx;
          ev_brk  = 1'b1;
          err_n   = is_pfx;
        end
        default: begin
          state_n = IDLE;
          ev      = !is_pfx;
          ev_ext  = 1'b1;
          ev_brk  = 1'b1;
          err_n   = is_pfx;
        end
      endcase
    else if (state != IDLE && expired) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end
  end

  // Inter-byte timer runs only while waiting for the byte that completes a prefix
  always_ff @(posedge clk or posedge rst)
    if (rst) timer <= '0;
    else     timer <= (ps2_valid || state == IDLE || expired) ? '0 : timer + TW'(1);

  // Registered key event outputs; translation sees modifier state before this byte's update
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      key_valid <= 1'b0;
      err       <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      ascii     <= 8'h00;
    end else begin
      key_valid <= ev;
      err       <= err_n;
      if (ev) begin
        key_code  <= ps2_data_in;
        key_ext   <= ev_ext;
        key_break <= ev_brk;
        ascii     <= ev_ext ? 8'h00 : to_ascii(ps2_data_in, shift ^ caps);
      end
    end

  // Modifier tracking; caps_held stops typematic repeats of caps-lock from re-toggling
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      caps_held <= 1'b0;
      caps      <= 1'b0;
    end else if (ev && !ev_ext) begin
      if (ps2_data_in == 8'h12) shift_l <= !ev_brk;
      if (ps2_data_in == 8'h59) shift_r <= !ev_brk;
      if (ps2_data_in == 8'h58) begin
        caps_held <= !ev_brk;
        if (!ev_brk && !caps_held) caps <= !caps;
      end
    end
endmodule
